// File: rtl/seg_display_pkg.sv
// seg_display_pkg: scan states, digit one-hot codes and default prescale for the display scanner.
// SEG_SCAN_GHOST_BLANK_EN adds the blanking states.
package seg_display_pkg;
`ifdef SEG_SCAN_GHOST_BLANK_EN
    typedef enum logic [2:0] {IDLE, SCAN_H, SCAN_D, SCAN_U, BLANK_H, BLANK_D, BLANK_U} scan_state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN_H, SCAN_D, SCAN_U} scan_state_t;
`endif
    localparam logic [2:0] DIGIT_H = 3'b100;
    localparam logic [2:0] DIGIT_D = 3'b010;
    localparam logic [2:0] DIGIT_U = 3'b001;
    localparam int PRESCALE_DEFAULT = 50000;
endpackage

// File: rtl/seg_display_scan_if.sv
// seg_display_scan_if: pattern inputs, enable and multiplexed display outputs of the scanner.
interface seg_display_scan_if #(parameter int WIDTH_OUTPUT_LENGTH = 7);
    logic                           Enable;
    logic [WIDTH_OUTPUT_LENGTH-1:0] SegHundreds;
    logic [WIDTH_OUTPUT_LENGTH-1:0] SegDozens;
    logic [WIDTH_OUTPUT_LENGTH-1:0] SegUnits;
    logic [WIDTH_OUTPUT_LENGTH-1:0] SegOut;
    logic [2:0]                     DigitEn;
    logic                           FrameStart;
    modport master (output Enable, SegHundreds, SegDozens, SegUnits, input SegOut, DigitEn, FrameStart);
    modport slave  (input Enable, SegHundreds, SegDozens, SegUnits, output SegOut, DigitEn, FrameStart);
endinterface

// File: rtl/seg_scan_prescaler.sv
// seg_scan_prescaler: digit dwell counter; Tick marks the last cycle of a PRESCALE-cycle slot.
module seg_scan_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    output logic Tick
);
    localparam int CW = $clog2(PRESCALE);
    logic [CW-1:0] cnt;
    assign Tick = cnt == CW'(PRESCALE - 1);
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) cnt <= '0;
        else cnt <= (Clear || Tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan: time-multiplexed 3-digit seven-segment scanner with per-frame snapshot.
// SEG_SCAN_GHOST_BLANK_EN inserts a one-cycle all-off state before each digit.
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int WIDTH_OUTPUT_LENGTH = 7,
    parameter int PRESCALE            = PRESCALE_DEFAULT
) (
    input logic               Clk,
    input logic               Rst,
    seg_display_scan_if.slave bus
);
`ifdef SEG_SCAN_GHOST_BLANK_EN
    localparam scan_state_t TO_H = BLANK_H, TO_D = BLANK_D, TO_U = BLANK_U;
`else
    localparam scan_state_t TO_H = SCAN_H, TO_D = SCAN_D, TO_U = SCAN_U;
`endif
    scan_state_t state, nxt;
    logic [WIDTH_OUTPUT_LENGTH-1:0] snap_h, snap_d, snap_u, seg_nxt;
    logic [2:0] den_nxt;
    logic tick, new_frame;
    seg_scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clear (!(bus.Enable && (state inside {SCAN_H, SCAN_D, SCAN_U}))),
        .Tick  (tick)
    );
    assign new_frame = bus.Enable && (state == IDLE || (state == SCAN_U && tick));
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = TO_H;
            SCAN_H:  nxt = tick ? TO_D : SCAN_H;
            SCAN_D:  nxt = tick ? TO_U : SCAN_D;
            SCAN_U:  nxt = tick ? TO_H : SCAN_U;
`ifdef SEG_SCAN_GHOST_BLANK_EN
            BLANK_H: nxt = SCAN_H;
            BLANK_D: nxt = SCAN_D;
            BLANK_U: nxt = SCAN_U;
`endif
            default: nxt = IDLE;
        endcase
        if (!bus.Enable) nxt = IDLE;
    end
    // A frame start straight into SCAN_H must show the pattern being captured, not the stale snapshot.
    assign seg_nxt = nxt == SCAN_H ? (new_frame ? bus.SegHundreds : snap_h) :
                     nxt == SCAN_D ? snap_d :
                     nxt == SCAN_U ? snap_u : '0;
    assign den_nxt = nxt == SCAN_H ? DIGIT_H : nxt == SCAN_D ? DIGIT_D : nxt == SCAN_U ? DIGIT_U : 3'b000;
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) begin
            state          <= IDLE;
            snap_h         <= '0;
            snap_d         <= '0;
            snap_u         <= '0;
            bus.SegOut     <= '0;
            bus.DigitEn    <= 3'b000;
            bus.FrameStart <= 1'b0;
        end else begin
            state          <= nxt;
            bus.SegOut     <= seg_nxt;
            bus.DigitEn    <= den_nxt;
            bus.FrameStart <= new_frame;
            if (new_frame) begin
                snap_h <= bus.SegHundreds;
                snap_d <= bus.SegDozens;
                snap_u <= bus.SegUnits;
            end
        end
endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Time-multiplexing scanner that sits directly downstream of the CPU output port. It takes the three registered seven-segment patterns (hundreds, dozens, units) and drives one shared segment bus plus three one-hot digit enables, cycling digits at a programmable rate. It snapshots all three patterns at each frame start, so a CPU write mid-frame cannot tear the displayed value.

## Interface
- WIDTH_OUTPUT_LENGTH, 7: segment pattern width (gfedcba, bit 0 = a).
- PRESCALE, 50000: Clk cycles each digit is lit; legal range 2..2^20.
- Clk  input  1  system clock, rising-edge.
- Rst  input  1  reset, asynchronous and active-low.
- Enable  input  1  scan enable; low blanks the display.
- SegHundreds  input  WIDTH_OUTPUT_LENGTH  hundreds pattern from output port.
- SegDozens  input  WIDTH_OUTPUT_LENGTH  dozens pattern.
- SegUnits  input  WIDTH_OUTPUT_LENGTH  units pattern.
- SegOut  output  WIDTH_OUTPUT_LENGTH  shared segment bus, active-high.
- DigitEn  output  3  one-hot digit select: [2]=hundreds, [1]=dozens, [0]=units.
- FrameStart  output  1  one-cycle pulse on the cycle the snapshot is taken.

## Operation
- States: IDLE, SCAN_H, SCAN_D, SCAN_U (plus BLANK_H, BLANK_D, BLANK_U under macro).
- Reset (Rst=0): state IDLE, prescale counter 0, snapshot registers 0, SegOut=0, DigitEn=3'b000, FrameStart=0.
- IDLE: SegOut=0, DigitEn=0. On an edge with Enable=1: capture all three inputs into the snapshot, pulse FrameStart, go to SCAN_H with counter cleared.
- SCAN_x: SegOut = snapshot of digit x, DigitEn one-hot for x. Counter increments each cycle; on the cycle counter == PRESCALE-1 it clears and the state advances H->D->U->H.
- U->H transition re-captures the snapshot and pulses FrameStart. Snapshot is never updated at any other time.
- Counter width = $clog2(PRESCALE); wraps only by explicit clear, never by overflow.
- Enable low in any state: next edge enters IDLE, counter cleared, outputs zero. Re-enable restarts at SCAN_H with a fresh snapshot.
- Input change during a frame: not visible until the next FrameStart.
- Exactly one DigitEn bit is set in SCAN states. All bits are 0 in IDLE/BLANK states; two bits are never set.

## Timing
- All outputs are registered and change on the same edge as the state register.
- Enable sampled high at edge N: FrameStart=1 and DigitEn=3'b100 during cycle N..N+1; FrameStart returns to 0 at edge N+1.
- Each digit is lit for exactly PRESCALE cycles. Frame period is 3*PRESCALE cycles (3*PRESCALE+3 with blanking).
- Rst assertion mid-frame clears all outputs immediately, without waiting for a clock edge.

## Configuration
- SEG_SCAN_GHOST_BLANK_EN defined: a one-cycle BLANK state is inserted before each SCAN state (BLANK_H, BLANK_D, BLANK_U), with SegOut=0 and DigitEn=0.
  - The snapshot and FrameStart occur on entry to BLANK_H.
  - The counter does not run during BLANK.
- Undefined: SCAN states follow each other directly and the BLANK states do not exist.

## Structure
- Shared package seg_display_pkg holds:
  - typedef enum for scan states.
  - DIGIT_H/DIGIT_D/DIGIT_U one-hot localparams.
  - Default PRESCALE constant.
- One sub-module, seg_scan_prescaler: counter with clear input and terminal-count output `Tick`.
- The top level holds the FSM, snapshot registers and output registers.

## Test plan
- Reset with Enable=1, PRESCALE=4, inputs 7'h06/7'h5B/7'h4F; release Rst -> FrameStart one cycle, then 4 cycles SegOut=7'h06/DigitEn=100, 4 cycles 7'h5B/010, 4 cycles 7'h4F/001, repeat.
- Change SegUnits to 7'h66 during SCAN_H -> units slot still shows 7'h4F this frame and 7'h66 from the next frame.
- Drop Enable during SCAN_D -> next cycle SegOut=0, DigitEn=0. Raise Enable -> restarts at SCAN_H with FrameStart.
- Assert Rst mid-SCAN_U -> SegOut=0, DigitEn=0, FrameStart=0 immediately (asynchronously), before the next edge.
- With SEG_SCAN_GHOST_BLANK_EN, PRESCALE=4 -> frame is 15 cycles, one all-zero cycle precedes each digit, and FrameStart coincides with BLANK_H.
- Run 1000 frames with random input changes -> DigitEn never has more than one bit set, and each digit's lit duration equals PRESCALE.
